// File: rtl/stream_pkg.sv
// Shared definitions for the stream multiplexer family: mode encoding,
// output-buffer states and a constant clog2 helper for derived widths.
package stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after i_last, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own load enable.
module rr_arbiter #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic [N_CH-1:0]  o_gnt_oh,
    output logic [SEL_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    int w_best;
    int w_dist;

    // Distance from the channel just after i_last; smallest requesting distance wins.
    always_comb begin
        w_best    = N_CH;
        w_dist    = 0;
        o_gnt_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + N_CH - int'(i_last) - 1) % N_CH;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_gnt_idx = SEL_W'(i);
            end
        end
        o_gnt_vld = (w_best < N_CH);
    end

    always_comb begin
        o_gnt_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            o_gnt_oh[i] = o_gnt_vld && (o_gnt_idx == SEL_W'(i));
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux, fixed-select or round-robin, one output register.
// Latency: accepted word appears on out_data the cycle after the handshake.
// Backpressure: all in_ready low while the output holds a word and out_ready is low.
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = stream_pkg::clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    localparam int LSB_W = stream_pkg::clog2(N_CH*WIDTH);

    buf_state_t         r_state;
    buf_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_out_dat;
    logic [SEL_W-1:0]   r_out_ch;
    logic [SEL_W-1:0]   r_last_gnt;

    logic               w_load_en;
    logic [N_CH-1:0]    w_arb_oh;
    logic [SEL_W-1:0]   w_arb_idx;
    logic               w_arb_vld;
    logic [N_CH-1:0]    w_gnt_oh;
    logic [SEL_W-1:0]   w_gnt_idx;
    logic               w_gnt_vld;
    logic               w_accept;
    logic [LSB_W-1:0]   w_lsb;
    logic [WIDTH-1:0]   w_sel_dat;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .i_req     (in_valid),
        .i_last    (r_last_gnt),
        .o_gnt_oh  (w_arb_oh),
        .o_gnt_idx (w_arb_idx),
        .o_gnt_vld (w_arb_vld)
    );

    // rst_n is folded in so in_ready drops the moment reset asserts.
    assign w_load_en = rst_n && ((r_state == ST_EMPTY) || out_ready);

    always_comb begin
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
        if (mode == MODE_RR) begin
            w_gnt_oh  = w_arb_oh;
            w_gnt_idx = w_arb_idx;
            w_gnt_vld = w_arb_vld;
        end else if (int'(sel) < N_CH) begin
            w_gnt_idx = sel;
            w_gnt_vld = 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                w_gnt_oh[i] = (sel == SEL_W'(i));
            end
        end
    end

    assign in_ready = w_load_en ? w_gnt_oh : '0;
    assign w_accept = |(in_valid & in_ready);

    // Out-of-range selects leave w_gnt_idx at 0, so the part-select stays in bounds.
    assign w_lsb     = LSB_W'(w_gnt_idx) * LSB_W'(WIDTH);
    assign w_sel_dat = in_data[w_lsb +: WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_out_dat  <= '0;
            r_out_ch   <= '0;
            r_last_gnt <= SEL_W'(N_CH - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_out_dat <= w_sel_dat;
                r_out_ch  <= w_gnt_idx;
                if (mode == MODE_RR) begin
                    r_last_gnt <= w_gnt_idx;
                end
            end
        end
    end

    assign out_data  = r_out_dat;
    assign out_ch    = r_out_ch;
    assign out_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8x8 instance for the main behaviour
// and a 6-channel instance for out-of-range select handling.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst_n;

    logic [63:0] a_in_data;
    logic [7:0]  a_in_valid;
    logic [7:0]  a_in_ready;
    logic        a_mode;
    logic [2:0]  a_sel;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [2:0]  a_out_ch;

    logic [47:0] b_in_data;
    logic [5:0]  b_in_valid;
    logic [5:0]  b_in_ready;
    logic        b_mode;
    logic [2:0]  b_sel;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [2:0]  b_out_ch;

    int checks;
    int failures;

    stream_mux_rr #(.N_CH(8), .WIDTH(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .mode      (a_mode),
        .sel       (a_sel),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_ch    (a_out_ch)
    );

    stream_mux_rr #(.N_CH(6), .WIDTH(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ch    (b_out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        a_in_data   = '0;
        a_in_valid  = '0;
        a_mode      = 1'b0;
        a_sel       = 3'd0;
        a_out_ready = 1'b1;
        b_in_data   = '0;
        b_in_valid  = '0;
        b_mode      = 1'b0;
        b_sel       = 3'd0;
        b_out_ready = 1'b1;

        // Reset state: in_ready held low even though load would otherwise be enabled.
        tick();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data",  64'(a_out_data),  64'd0);
        chk("rst_out_ch",    64'(a_out_ch),    64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd0);
        tick();
        rst_n = 1'b1;

        // Fixed select: channel 5 only.
        a_in_data[5*8 +: 8] = 8'hA5;
        a_in_valid = 8'h20;
        a_sel      = 3'd5;
        #1;
        chk("fix_in_ready", 64'(a_in_ready), 64'h20);
        tick();
        chk("fix_out_valid", 64'(a_out_valid), 64'd1);
        chk("fix_out_data",  64'(a_out_data),  64'hA5);
        chk("fix_out_ch",    64'(a_out_ch),    64'd5);
        a_in_valid = 8'h00;
        #1;
        chk("fix_ready_no_valid", 64'(a_in_ready), 64'h20);
        tick();
        chk("drain_out_valid", 64'(a_out_valid), 64'd0);
        chk("drain_hold_data", 64'(a_out_data),  64'hA5);
        chk("drain_hold_ch",   64'(a_out_ch),    64'd5);

        // Round-robin fairness: pointer still 7 after fixed mode, so start at 0.
        for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'(8'h10 + i);
        a_mode     = 1'b1;
        a_in_valid = 8'hFF;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("rr_ch_%0d", i),    64'(a_out_ch),    64'(i % 8));
            chk($sformatf("rr_data_%0d", i),  64'(a_out_data),  64'(8'h10 + (i % 8)));
            chk($sformatf("rr_valid_%0d", i), 64'(a_out_valid), 64'd1);
        end

        // Sparse requests from last_grant=6: channel 7 idle, wrap to 0, then 2, then 0.
        a_in_valid = 8'b0000_0101;
        #1;
        chk("sparse_ready0", 64'(a_in_ready), 64'h01);
        tick();
        chk("sparse_ch0", 64'(a_out_ch), 64'd0);
        chk("sparse_ready1", 64'(a_in_ready), 64'h04);
        tick();
        chk("sparse_ch2", 64'(a_out_ch), 64'd2);
        tick();
        chk("sparse_ch0b", 64'(a_out_ch), 64'd0);
        chk("sparse_data", 64'(a_out_data), 64'h10);

        // Backpressure with channel 3 pending.
        a_out_ready = 1'b0;
        a_in_valid  = 8'h08;
        #1;
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_data_%0d", i),  64'(a_out_data),  64'h10);
            chk($sformatf("bp_ch_%0d", i),    64'(a_out_ch),    64'd0);
            chk($sformatf("bp_valid_%0d", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("bp_ready_%0d", i), 64'(a_in_ready),  64'd0);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(a_in_ready), 64'h08);
        tick();
        chk("bp_new_data",  64'(a_out_data),  64'h13);
        chk("bp_new_ch",    64'(a_out_ch),    64'd3);
        chk("bp_new_valid", 64'(a_out_valid), 64'd1);

        // Asynchronous reset mid-stream, away from the clock edge.
        a_in_valid = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_out_ch",    64'(a_out_ch),    64'd0);
        chk("arst_out_data",  64'(a_out_data),  64'd0);
        chk("arst_in_ready",  64'(a_in_ready),  64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ch",    64'(a_out_ch),    64'd0);
        chk("post_rst_valid", 64'(a_out_valid), 64'd1);

        // Six-channel instance: establish last_grant=2 in RR mode.
        for (int i = 0; i < 6; i++) b_in_data[i*8 +: 8] = 8'(8'h20 + i);
        b_mode     = 1'b1;
        b_in_valid = 6'b000100;
        tick();
        chk("b_rr_ch",   64'(b_out_ch),   64'd2);
        chk("b_rr_data", 64'(b_out_data), 64'h22);

        // Select 7 is beyond the channel count: no grant, output drains.
        b_mode     = 1'b0;
        b_sel      = 3'd7;
        b_in_valid = 6'h3F;
        #1;
        chk("b_oor_ready", 64'(b_in_ready), 64'd0);
        tick();
        chk("b_oor_valid", 64'(b_out_valid), 64'd0);
        chk("b_oor_hold",  64'(b_out_data),  64'h22);
        tick();
        chk("b_oor_valid2", 64'(b_out_valid), 64'd0);
        chk("b_oor_ready2", 64'(b_in_ready),  64'd0);

        // Back to round-robin: resumes after the preserved pointer at 2.
        b_mode = 1'b1;
        #1;
        chk("b_resume_ready", 64'(b_in_ready), 64'h08);
        tick();
        chk("b_resume_ch",   64'(b_out_ch),   64'd3);
        chk("b_resume_data", 64'(b_out_data), 64'h23);
        tick();
        chk("b_resume_ch2",  64'(b_out_ch),   64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
